// File: rtl/sr_piso.sv
// rtl/sr_piso.sv - parallel-in serial-out shifter with load/ready handshake
// Back-to-back loads are taken in the last-bit cycle so the serial stream has no gaps.
module sr_piso #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH:1]   din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_nx;
  logic [WIDTH:1] shreg, shreg_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           valid_nx, done_nx;
  logic           is_last;

  assign is_last = (state == SHIFT) && (cnt == LAST);
  assign ready   = (state == IDLE) || is_last;
  assign sout    = valid ? (MSB_FIRST ? shreg[WIDTH] : shreg[1]) : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
      valid <= valid_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    valid_nx = valid;
    done_nx  = done;
    if (load && ready) begin
      state_nx = SHIFT;
      shreg_nx = din;
      cnt_nx   = '0;
      valid_nx = 1'b1;
      done_nx  = (WIDTH == 1);
    end else if (state == SHIFT) begin
      if (!is_last) begin
        // Move the next bit toward the end that drives sout.
        if (MSB_FIRST) shreg_nx = {shreg[WIDTH-1:1], 1'b0};
        else           shreg_nx = {1'b0, shreg[WIDTH:2]};
        cnt_nx  = cnt + CW'(1);
        done_nx = (cnt_nx == LAST);
      end else begin
        state_nx = IDLE;
        shreg_nx = '0;
        cnt_nx   = '0;
        valid_nx = 1'b0;
        done_nx  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sr_piso.sv
// tb/tb_sr_piso.sv - self-checking bench for sr_piso, MSB-first and LSB-first instances
// Reference: a queue of (bit, last) entries, one per upcoming output cycle.
module tb_sr_piso;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W:1]   din = '0;
  logic         load = 1'b0;
  logic         ready_m, sout_m, valid_m, done_m;
  logic         ready_l, sout_l, valid_l, done_l;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0] qm[$];
  logic [1:0] ql[$];

  always #5 clk = ~clk;

  sr_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .load(load),
    .ready(ready_m), .sout(sout_m), .valid(valid_m), .done(done_m)
  );

  sr_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .load(load),
    .ready(ready_l), .sout(sout_l), .valid(valid_l), .done(done_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A word occupies WIDTH output cycles; a new one is accepted only when at most one remains.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qm.delete();
      ql.delete();
    end else begin
      logic acc;
      acc = load && (qm.size() <= 1);
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back({din[W - i], 1'(i == W - 1)});
          ql.push_back({din[1 + i], 1'(i == W - 1)});
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("msb_valid", 32'(valid_m), 32'(qm.size() > 0));
    chk("msb_sout",  32'(sout_m),  32'(qm.size() > 0 ? qm[0][1] : 1'b0));
    chk("msb_done",  32'(done_m),  32'(qm.size() > 0 ? qm[0][0] : 1'b0));
    chk("msb_ready", 32'(ready_m), 32'(qm.size() <= 1));
    chk("lsb_valid", 32'(valid_l), 32'(ql.size() > 0));
    chk("lsb_sout",  32'(sout_l),  32'(ql.size() > 0 ? ql[0][1] : 1'b0));
    chk("lsb_done",  32'(done_l),  32'(ql.size() > 0 ? ql[0][0] : 1'b0));
    chk("lsb_ready", 32'(ready_l), 32'(ql.size() <= 1));
  end

  // Caller has just driven the first load; records n cycles, first cycle in the top bit.
  task automatic capture(input int n, input int k2, input logic [W:1] d2,
                         output logic [15:0] s_m, output logic [15:0] s_l,
                         output logic [15:0] dn, output logic [15:0] vl,
                         output logic [15:0] rd);
    s_m = '0; s_l = '0; dn = '0; vl = '0; rd = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_m[n-1-k] = sout_m;
      s_l[n-1-k] = sout_l;
      dn[n-1-k]  = done_m;
      vl[n-1-k]  = valid_m;
      rd[n-1-k]  = ready_l;
      if (k == k2) begin
        load = 1'b1;
        din  = d2;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic start(input logic [W:1] d);
    @(negedge clk);
    load = 1'b1;
    din  = d;
  endtask

  initial begin
    logic [15:0] s_m, s_l, dn, vl, rd;

    repeat (2) @(negedge clk);
    chk("reset_sout", 32'(sout_m | sout_l), 32'd0);
    chk("reset_ready", 32'({ready_m, ready_l}), 32'd3);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_valid", 32'(valid_m | valid_l | done_m | done_l), 32'd0);

    start(4'b1011);
    capture(5, -1, '0, s_m, s_l, dn, vl, rd);
    chk("msb_word_sout", 32'(s_m[4:0]), 32'b10110);
    chk("msb_word_done", 32'(dn[4:0]), 32'b00010);
    chk("msb_word_valid", 32'(vl[4:0]), 32'b11110);
    chk("lsb_word_sout", 32'(s_l[4:0]), 32'b11010);
    chk("lsb_word_ready", 32'(rd[4:0]), 32'b00011);

    start(4'b1100);
    capture(9, 3, 4'b0101, s_m, s_l, dn, vl, rd);
    chk("b2b_msb_sout", 32'(s_m[8:0]), 32'b110001010);
    chk("b2b_lsb_sout", 32'(s_l[8:0]), 32'b001110100);
    chk("b2b_done", 32'(dn[8:0]), 32'b000100010);
    chk("b2b_valid", 32'(vl[8:0]), 32'b111111110);

    start(4'b1111);
    capture(6, 1, 4'b0000, s_m, s_l, dn, vl, rd);
    chk("busy_sout", 32'(s_m[5:0]), 32'b111100);
    chk("busy_valid", 32'(vl[5:0]), 32'b111100);

    start(4'b1010);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset_out", 32'({sout_m, valid_m, done_m, sout_l, valid_l, done_l}), 32'd0);
    chk("midreset_ready", 32'({ready_m, ready_l}), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    start(4'b0110);
    capture(5, -1, '0, s_m, s_l, dn, vl, rd);
    chk("after_reset_msb", 32'(s_m[4:0]), 32'b01100);
    chk("after_reset_lsb", 32'(s_l[4:0]), 32'b01100);
    chk("after_reset_done", 32'(dn[4:0]), 32'b00010);

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 9) < 6);
      din  = W'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        #1 chk("rand_reset_valid", 32'(valid_m | valid_l), 32'd0);
        @(negedge clk);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
